// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial adder: controller states and the
// supported operand-width range.
package add_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_bit_cell.sv
// One-bit full adder built from two half adders with the carries ORed.
module add_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s_ab;
  logic c_ab;
  logic c_sc;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s_ab),
    .c (c_ab)
  );

  half_adder u_ha1 (
    .a (s_ab),
    .b (cin),
    .s (s),
    .c (c_sc)
  );

  assign cout = c_ab | c_sc;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: accepts an operand pair, adds one bit per clock
// LSB first through a single adder cell, then presents sum and carry-out.
module serial_add_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_c;
  logic             accept;
  logic             run_done;
  logic             release_res;

  add_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_c)
  );

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  // RUN spends WIDTH edges shifting and one more committing the result,
  // which keeps out_sum stable while the next operand pair is being added.
  assign run_done    = (cnt == CNT_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = RUN;
      RUN:     if (run_done)    state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            carry  <= in_cin;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (!run_done) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= (sum_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
            carry  <= cell_c;
            cnt    <= cnt + CNT_W'(1);
          end else begin
            out_sum  <= sum_sh;
            out_cout <= carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       busy;

  logic       w1_in_valid;
  logic       w1_in_ready;
  logic [0:0] w1_in_a;
  logic [0:0] w1_in_b;
  logic       w1_in_cin;
  logic       w1_out_valid;
  logic       w1_out_ready;
  logic [0:0] w1_out_sum;
  logic       w1_out_cout;
  logic       w1_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .in_a      (w1_in_a),
    .in_b      (w1_in_b),
    .in_cin    (w1_in_cin),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .out_sum   (w1_out_sum),
    .out_cout  (w1_out_cout),
    .busy      (w1_busy)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Starts in IDLE at #1 after an edge; returns in IDLE when rdy=1, or still
  // in DONE when rdy=0. lat counts edges from the accept edge to out_valid.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic rdy, output logic [7:0] s, output logic c,
                       output int lat);
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_valid  = 1'b1;
    out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = out_sum;
    c = out_cout;
    if (rdy) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op1(input logic a, input logic b, input logic cin,
                        output logic s, output logic c, output int lat);
    w1_in_a      = a;
    w1_in_b      = b;
    w1_in_cin    = cin;
    w1_in_valid  = 1'b1;
    w1_out_ready = 1'b1;
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    lat = 0;
    while (!w1_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = w1_out_sum[0];
    c = w1_out_cout;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] s;
    logic       c;
    logic       s1;
    logic       c1;
    int         lat;
    logic [7:0] held_sum;
    logic       held_cout;
    logic       saw_valid;
    logic [8:0] model;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_cin       = 1'b0;
    out_ready    = 1'b0;
    w1_in_valid  = 1'b0;
    w1_in_a      = '0;
    w1_in_b      = '0;
    w1_in_cin    = 1'b0;
    w1_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_sum", 32'(out_sum), 32'h00);
    chk("reset_out_cout", 32'(out_cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Busy starts right after the accept edge.
    in_a = 8'h35; in_b = 8'h4A; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_in_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("basic_latency", 32'(lat), 32'd9);
    chk("basic_sum", 32'(out_sum), 32'h7F);
    chk("basic_busy_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, s, c, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
    end

    // Backpressure: result held, new operands ignored.
    do_op(8'h3C, 8'h21, 1'b1, 1'b0, s, c, lat);
    chk("bp_sum", 32'(s), 32'h5E);
    held_sum  = out_sum;
    held_cout = out_cout;
    in_a = 8'h11; in_b = 8'h22; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_sum_stable_%0d", i), 32'(out_sum), 32'(held_sum));
      chk($sformatf("bp_cout_stable_%0d", i), 32'(out_cout), 32'(held_cout));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_sum_kept", 32'(out_sum), 32'h5E);
    @(posedge clk); #1;
    chk("bp_no_late_accept", 32'(busy), 32'd0);

    // Reset mid-run discards the partial result.
    in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'h00);
    chk("abort_out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_never_valid", 32'(saw_valid), 32'd0);
    do_op(8'h01, 8'h01, 1'b0, 1'b1, s, c, lat);
    chk("after_abort_sum", 32'(s), 32'h02);
    chk("after_abort_cout", 32'(c), 32'd0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      do_op(ra, rb, rc, 1'b1, s, c, lat);
      chk($sformatf("rand%0d_a%0h_b%0h_c%0d", i, ra, rb, rc), 32'({c, s}), 32'(model));
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] m1;
      v  = 3'(i);
      m1 = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      do_op1(v[2], v[1], v[0], s1, c1, lat);
      chk($sformatf("w1_combo%0d", i), 32'({c1, s1}), 32'(m1));
      chk($sformatf("w1_latency%0d", i), 32'(lat), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
